// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: steps the digit index at a fixed
// refresh rate and double-buffers the displayed value so updates land only on frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int COUNT_MAX = 100000,
  parameter int N         = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  value,
  input  logic         load,
  input  logic         blank_lz,
  input  logic [7:0]   dp_mask,
  output logic [N-1:0] sel,
  output logic [6:0]   segments,
  output logic         dp,
  output logic         frame_done
);

  localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  // COUNT_MAX-1 always fits in CW bits, so the terminal count is exact.
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);

  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sel;
  logic [31:0]   r_shadow;
  logic [31:0]   r_disp;
  logic          r_pending;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_wrap;
  logic [3:0]    w_nib;
  logic [2:0]    w_msd;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_tick = (r_cnt == CNT_LAST);
  assign w_wrap = w_tick && (&r_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_sel        <= '0;
      r_shadow     <= '0;
      r_disp       <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
      r_frame_done <= w_wrap;
      if (w_tick) r_sel <= r_sel + 1'b1;
      // A load coinciding with the wrap bypasses the shadow so it shows next frame.
      if (w_wrap) begin
        if (load) begin
          r_disp    <= value;
          r_shadow  <= value;
          r_pending <= 1'b0;
        end else if (r_pending) begin
          r_disp    <= r_shadow;
          r_pending <= 1'b0;
        end
      end else if (load) begin
        r_shadow  <= value;
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_msd = '0;
    for (int k = 1; k < 8; k++) begin
      if (r_disp[4*k +: 4] != 4'h0) w_msd = 3'(k);
    end
  end

  assign w_nib      = r_disp[{r_sel, 2'b00} +: 4];
  assign segments   = (blank_lz && (r_sel > w_msd)) ? 7'h7F : seg_decode(w_nib);
  assign dp         = ~dp_mask[r_sel];
  assign sel        = r_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl with COUNT_MAX=4: stimulus queues the
// expected per-slot display, a monitor checks every cycle of every digit slot.
module tb_seven_seg_scan_ctrl;

  localparam int CM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        load;
  logic        blank_lz;
  logic [7:0]  dp_mask;
  logic [2:0]  sel;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_done;

  typedef struct {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } slot_t;

  slot_t q[$];
  slot_t cur;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    done = 0;
  bit    started = 0;
  int    len = 0;
  logic [2:0] prev_sel;

  seven_seg_scan_ctrl #(.COUNT_MAX(CM), .N(3)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .sel(sel), .segments(segments), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [55:0] segs8(input logic [6:0] d0, d1, d2, d3, d4, d5, d6, d7);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  // Monitor: a change of sel marks a new digit slot presented by the DUT.
  always @(negedge clk) begin
    if (reset) begin
      started = 0;
    end else if (!done) begin
      if (!started || sel != prev_sel) begin
        if (started) chk("slot_len", len, CM);
        if (q.size() == 0) begin
          chk("queue_underflow", 1, 0);
        end else begin
          cur = q.pop_front();
          chk("sel", sel, cur.sel);
          chk("segments", segments, cur.seg);
          chk("dp", dp, cur.dp);
          chk("frame_done_first", frame_done, cur.fd);
        end
        len = 1;
        started = 1;
        prev_sel = sel;
      end else begin
        len++;
        chk("segments_hold", segments, cur.seg);
        chk("dp_hold", dp, cur.dp);
        chk("frame_done_hold", frame_done, 1'b0);
      end
    end
  end

  // Called at posedge+1 at the start of slot 0; leaves at posedge+1 after the last slot.
  task automatic run_frame(input logic [55:0] segs, input logic [7:0] dps, input logic fd0,
                           input int nslots, input int la_sel, input logic la_wrap,
                           input logic [31:0] la_val, input int lb_sel, input logic [31:0] lb_val);
    slot_t it;
    for (int k = 0; k < nslots; k++) begin
      it.sel = 3'(k);
      it.seg = segs[7*k +: 7];
      it.dp  = dps[k];
      it.fd  = (k == 0) ? fd0 : 1'b0;
      q.push_back(it);
      for (int j = 0; j < CM; j++) begin
        if (k == la_sel && (la_wrap ? (j == CM-1) : (j == 0))) begin
          value = la_val;
          load  = 1'b1;
        end
        if (k == lb_sel && j == 0) begin
          value = lb_val;
          load  = 1'b1;
        end
        @(posedge clk);
        #1 load = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    slot_t it;
    logic [55:0] s_blank0;
    reset = 1'b1; value = '0; load = 1'b0; blank_lz = 1'b0; dp_mask = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sel", sel, 3'd0);
    chk("reset_segments", segments, 7'h40);
    chk("reset_dp", dp, 1'b1);
    chk("reset_frame_done", frame_done, 1'b0);
    reset = 1'b0;

    run_frame(segs8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 8'hFF, 1'b0,
              8, 7, 1'b1, 32'h89ABCDEF, -1, 32'h0);
    run_frame(segs8(7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00), 8'hFF, 1'b1,
              8, 3, 1'b0, 32'h11111111, -1, 32'h0);
    run_frame(segs8(7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79), 8'hFF, 1'b1,
              8, 2, 1'b0, 32'h55555555, 6, 32'h22222222);
    run_frame(segs8(7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24), 8'hFF, 1'b1,
              8, 7, 1'b1, 32'h00000305, -1, 32'h0);
    blank_lz = 1'b1;
    run_frame(segs8(7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F), 8'hFF, 1'b1,
              8, 7, 1'b1, 32'h00000000, -1, 32'h0);
    dp_mask = 8'h81;
    s_blank0 = segs8(7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    run_frame(s_blank0, 8'h7E, 1'b1, 8, -1, 1'b0, 32'h0, -1, 32'h0);

    // Pending load at sel=2, then reset in the middle of slot 5.
    run_frame(s_blank0, 8'h7E, 1'b1, 5, 2, 1'b0, 32'h77777777, -1, 32'h0);
    it.sel = 3'd5; it.seg = 7'h7F; it.dp = 1'b1; it.fd = 1'b0;
    q.push_back(it);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_sel", sel, 3'd0);
    chk("async_reset_segments", segments, 7'h40);
    chk("async_reset_dp", dp, 1'b0);
    chk("async_reset_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_frame(s_blank0, 8'h7E, 1'b0, 8, -1, 1'b0, 32'h0, -1, 32'h0);
    run_frame(s_blank0, 8'h7E, 1'b1, 8, -1, 1'b0, 32'h0, -1, 32'h0);

    done = 1;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
